full_adder_chk: RTL and testbench

FULL_ADDER_CHK -- requirements
Module: full_adder_chk

---
 rtl/full_adder_chk_pkg.sv | 28 ++
 rtl/full_adder_chk_ref.sv | 25 ++
 rtl/full_adder_chk.sv | 165 ++++++++++++++++
 tb/tb_full_adder_chk.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_adder_chk_pkg.sv
// -----------------------------------------------------------------------------
// full_adder_chk_pkg
//
// Purpose : Shared definitions for the full-adder checker: FSM state encodings,
//           the "all stimulus seen" coverage constant and a small helper that
//           turns a 3-bit stimulus code into its coverage bit.
//           This package is the common home for the values other benches and
//           blocks reuse (IDLE=2'd0, RUN=2'd1, DONE=2'd2, COV_ALL=8'hFF).
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package full_adder_chk_pkg;

    // FSM state encodings kept as plain localparams so legacy code that
    // compares against raw 2-bit values keeps working.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Coverage word with every stimulus {ai,bi,ci} = 0..7 observed.
    localparam logic [7:0] COV_ALL = 8'hFF;

    // One-hot coverage bit for a stimulus code.
    function automatic logic [7:0] covBit(input logic [2:0] code);
        return 8'd1 << code;
    endfunction

endpackage

// File: rtl/full_adder_chk_ref.sv
// -----------------------------------------------------------------------------
// full_adder_ref
//
// Purpose : Combinational golden model of a 1-bit full adder. Kept as its own
//           module so other checkers and benches can reuse the same reference.
//
// Ports   : ai, bi, ci   - operand bits and carry-in
//           exp_so       - expected sum      (ai ^ bi ^ ci)
//           exp_co       - expected carry    (majority of ai, bi, ci)
// -----------------------------------------------------------------------------
module full_adder_ref (
    input  logic ai,
    input  logic bi,
    input  logic ci,
    output logic exp_so,
    output logic exp_co
);

    // Sum is the parity of the three inputs.
    assign exp_so = ai ^ bi ^ ci;

    // Carry is set whenever at least two inputs are set.
    assign exp_co = (ai & bi) | (ai & ci) | (bi & ci);

endmodule

// File: rtl/full_adder_chk.sv
// -----------------------------------------------------------------------------
// full_adder_chk
//
// Purpose : On-line checker for a 1-bit full adder. A run is started with a
//           one-cycle start pulse; the next NUM_VEC accepted vectors are
//           compared against the full_adder_ref golden model. The block counts
//           mismatches, records which of the 8 stimulus codes were exercised
//           and, at the end of the run, registers a pass/fail verdict.
//
// Parameters:
//           NUM_VEC - accepted vectors per run (1..255)
//           CNT_W   - width of the error counter
//
// Ports   : clk        - clock, all state changes on the rising edge
//           rst        - synchronous active-high reset
//           start      - one-cycle pulse, begins (or restarts) a run
//           in_vld     - ai/bi/ci/so/co are valid this cycle
//           ai,bi,ci   - stimulus applied to the adder under test
//           so,co      - sum/carry returned by the adder under test
//           busy       - high while in RUN
//           done       - high while in DONE
//           pass       - verdict, meaningful while done=1
//           err_pulse  - one-cycle flag, the cycle after a mismatching vector
//           err_cnt    - saturating count of mismatching vectors
//           cov        - bit k set when stimulus {ai,bi,ci}==k has been seen
//           first_err  - only with FULL_ADDER_CHK_FIRST_ERR_EN defined:
//                        {ai,bi,ci,so,co,1'b1} of the first mismatch of the
//                        run, 0 when there has been no mismatch
//
// Build option: `define FULL_ADDER_CHK_FIRST_ERR_EN adds the first_err capture.
// -----------------------------------------------------------------------------
module full_adder_chk
    import full_adder_chk_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_vld,
    input  logic             ai,
    input  logic             bi,
    input  logic             ci,
    input  logic             so,
    input  logic             co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       cov
`ifdef FULL_ADDER_CHK_FIRST_ERR_EN
    ,
    output logic [5:0]       first_err
`endif
);

    // NUM_VEC never exceeds 255, so an 8-bit vector counter is always enough.
    localparam logic [7:0] LP_NUM_VEC = 8'(NUM_VEC);

    logic [1:0]       r_state;
    logic [7:0]       r_vecCnt;
    logic [CNT_W-1:0] r_errCnt;
    logic [7:0]       r_cov;
    logic             r_pass;
    logic             r_errPulse;

    logic             w_expSo;
    logic             w_expCo;
    logic             w_accept;
    logic             w_mismatch;
    logic [2:0]       w_stim;
    logic [7:0]       w_vecCntNext;
    logic [CNT_W-1:0] w_errCntNext;
    logic [7:0]       w_covNext;
    logic             w_lastVec;

    full_adder_ref u_ref (
        .ai     (ai),
        .bi     (bi),
        .ci     (ci),
        .exp_so (w_expSo),
        .exp_co (w_expCo)
    );

    // A vector only counts in RUN, and a simultaneous start wins over it so
    // the vector is dropped rather than leaking into the restarted run.
    assign w_accept   = (r_state == RUN) && in_vld && !start;
    assign w_mismatch = (so != w_expSo) || (co != w_expCo);
    assign w_stim     = {ai, bi, ci};

    // Post-update values of the run statistics. The verdict at the end of the
    // run must include the final vector, so it is computed from these rather
    // than from the registers.
    assign w_vecCntNext = r_vecCnt + 8'd1;
    assign w_covNext    = r_cov | covBit(w_stim);
    assign w_errCntNext = (w_mismatch && (r_errCnt != {CNT_W{1'b1}}))
                          ? r_errCnt + CNT_W'(1)
                          : r_errCnt;
    assign w_lastVec    = (w_vecCntNext == LP_NUM_VEC);

    // Main checker FSM and run statistics. start restarts the run from any
    // state; otherwise only accepted vectors change anything, which also
    // makes DONE hold its results while in_vld keeps toggling.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_vecCnt   <= 8'd0;
            r_errCnt   <= '0;
            r_cov      <= 8'd0;
            r_pass     <= 1'b0;
            r_errPulse <= 1'b0;
        end else begin
            r_errPulse <= 1'b0;
            if (start) begin
                r_state  <= RUN;
                r_vecCnt <= 8'd0;
                r_errCnt <= '0;
                r_cov    <= 8'd0;
                r_pass   <= 1'b0;
            end else if (w_accept) begin
                r_vecCnt   <= w_vecCntNext;
                r_cov      <= w_covNext;
                r_errCnt   <= w_errCntNext;
                r_errPulse <= w_mismatch;
                if (w_lastVec) begin
                    r_state <= DONE;
                    r_pass  <= (w_errCntNext == '0) && (w_covNext == COV_ALL);
                end
            end else if ((r_state != IDLE) && (r_state != RUN) && (r_state != DONE)) begin
                // The unused encoding falls back to IDLE.
                r_state <= IDLE;
            end
        end
    end

    // Status flags decode straight from the state register, so they are
    // glitch-free and can never be high together.
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign err_pulse = r_errPulse;
    assign err_cnt   = r_errCnt;
    assign cov       = r_cov;

`ifdef FULL_ADDER_CHK_FIRST_ERR_EN
    logic [5:0] r_firstErr;

    // Bit 0 of the capture is a constant 1, so it doubles as the
    // "already captured" flag and keeps later errors from overwriting it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_firstErr <= 6'd0;
        end else if (start) begin
            r_firstErr <= 6'd0;
        end else if (w_accept && w_mismatch && !r_firstErr[0]) begin
            r_firstErr <= {ai, bi, ci, so, co, 1'b1};
        end
    end

    assign first_err = r_firstErr;
`endif

endmodule

// File: tb/tb_full_adder_chk.sv
// -----------------------------------------------------------------------------
// tb_full_adder_chk
//
// Purpose : Self-checking bench for full_adder_chk. Expected sum/carry come
//           from arithmetic on the stimulus (popcount), and run statistics
//           (error count, coverage word, verdict) are tracked by the bench
//           itself. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_full_adder_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_vld;
    logic       ai;
    logic       bi;
    logic       ci;
    logic       so;
    logic       co;
    logic       busy;
    logic       done;
    logic       pass;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [7:0] cov;
`ifdef FULL_ADDER_CHK_FIRST_ERR_EN
    logic [5:0] first_err;
`endif

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    full_adder_chk #(
        .NUM_VEC (16),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_vld    (in_vld),
        .ai        (ai),
        .bi        (bi),
        .ci        (ci),
        .so        (so),
        .co        (co),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .cov       (cov)
`ifdef FULL_ADDER_CHK_FIRST_ERR_EN
        ,
        .first_err (first_err)
`endif
    );

    // Correct {sum, carry} for a stimulus code: sum is the popcount's low
    // bit, carry is set when two or more inputs are set.
    function automatic logic [1:0] goodOut(input logic [2:0] k);
        int n;
        n = int'(k[2]) + int'(k[1]) + int'(k[0]);
        return {((n % 2) == 1), (n >= 2)};
    endfunction

    // Drive one cycle of inputs (we are at a falling edge), let one rising
    // edge pass, and return err_pulse as seen in the following cycle.
    task automatic step(input logic st, input logic vld, input logic [2:0] k,
                        input logic s, input logic c, output logic pulse);
        start  = st;
        in_vld = vld;
        {ai, bi, ci} = k;
        so = s;
        co = c;
        @(negedge clk);
        pulse = err_pulse;
    endtask

    task automatic test_reset();
        // Reset must win even with start and in_vld high.
        rst = 1'b1; start = 1'b1; in_vld = 1'b1;
        {ai, bi, ci} = 3'd7; so = 1'b0; co = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nVec++; if (busy !== 1'b0) begin nMis++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        nVec++; if (done !== 1'b0) begin nMis++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        nVec++; if (pass !== 1'b0) begin nMis++; $display("[TB] FAIL reset_pass: got %b want 0", pass); end
        nVec++; if (err_pulse !== 1'b0) begin nMis++; $display("[TB] FAIL reset_err_pulse: got %b want 0", err_pulse); end
        nVec++; if (err_cnt !== 8'd0) begin nMis++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        nVec++; if (cov !== 8'h00) begin nMis++; $display("[TB] FAIL reset_cov: got %h want 00", cov); end
        rst = 1'b0; start = 1'b0; in_vld = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_correct();
        logic       p;
        logic [1:0] g;
        logic [2:0] k;
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        nVec++; if (busy !== 1'b1 || done !== 1'b0) begin nMis++; $display("[TB] FAIL start_state: busy=%b done=%b want busy=1 done=0", busy, done); end
        for (int i = 0; i < 16; i++) begin
            k = 3'(i % 8);
            g = goodOut(k);
            step(1'b0, 1'b1, k, g[1], g[0], p);
            nVec++; if (p !== 1'b0) begin nMis++; $display("[TB] FAIL correct_pulse[%0d]: got %b want 0", i, p); end
        end
        nVec++; if (done !== 1'b1 || busy !== 1'b0) begin nMis++; $display("[TB] FAIL correct_done: done=%b busy=%b want 1/0", done, busy); end
        nVec++; if (pass !== 1'b1) begin nMis++; $display("[TB] FAIL correct_pass: got %b want 1", pass); end
        nVec++; if (err_cnt !== 8'd0) begin nMis++; $display("[TB] FAIL correct_err_cnt: got %0d want 0", err_cnt); end
        nVec++; if (cov !== 8'hFF) begin nMis++; $display("[TB] FAIL correct_cov: got %h want ff", cov); end
        // A bad vector while DONE must be ignored.
        step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, p);
        nVec++; if (p !== 1'b0) begin nMis++; $display("[TB] FAIL done_ignore_pulse: got %b want 0", p); end
        nVec++; if (err_cnt !== 8'd0 || pass !== 1'b1 || done !== 1'b1) begin nMis++; $display("[TB] FAIL done_hold: err_cnt=%0d pass=%b done=%b want 0/1/1", err_cnt, pass, done); end
    endtask

    task automatic test_stuck_co();
        logic       p;
        logic [1:0] g;
        logic [2:0] k;
        int         pulses = 0;
        // Started from DONE: must behave like a start from IDLE.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        nVec++; if (busy !== 1'b1 || err_cnt !== 8'd0 || cov !== 8'h00 || pass !== 1'b0) begin nMis++; $display("[TB] FAIL restart_from_done: busy=%b err_cnt=%0d cov=%h pass=%b", busy, err_cnt, cov, pass); end
        for (int i = 0; i < 16; i++) begin
            k = 3'(i % 8);
            g = goodOut(k);
            step(1'b0, 1'b1, k, g[1], 1'b0, p);
            if (p === 1'b1) pulses++;
            nVec++; if (p !== g[0]) begin nMis++; $display("[TB] FAIL stuck_pulse[%0d]: got %b want %b", i, p, g[0]); end
        end
        nVec++; if (pulses != 8) begin nMis++; $display("[TB] FAIL stuck_pulse_total: got %0d want 8", pulses); end
        nVec++; if (err_cnt !== 8'd8) begin nMis++; $display("[TB] FAIL stuck_err_cnt: got %0d want 8", err_cnt); end
        nVec++; if (pass !== 1'b0 || done !== 1'b1) begin nMis++; $display("[TB] FAIL stuck_verdict: pass=%b done=%b want 0/1", pass, done); end
        nVec++; if (cov !== 8'hFF) begin nMis++; $display("[TB] FAIL stuck_cov: got %h want ff", cov); end
    endtask

    task automatic test_partial_cov();
        logic       p;
        logic [1:0] g;
        logic [2:0] k;
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        for (int i = 0; i < 16; i++) begin
            k = 3'(i % 4);
            g = goodOut(k);
            step(1'b0, 1'b1, k, g[1], g[0], p);
        end
        nVec++; if (err_cnt !== 8'd0) begin nMis++; $display("[TB] FAIL partial_err_cnt: got %0d want 0", err_cnt); end
        nVec++; if (cov !== 8'h0F) begin nMis++; $display("[TB] FAIL partial_cov: got %h want 0f", cov); end
        nVec++; if (pass !== 1'b0 || done !== 1'b1) begin nMis++; $display("[TB] FAIL partial_verdict: pass=%b done=%b want 0/1", pass, done); end
    endtask

    task automatic test_restart_random();
        logic       p;
        logic [1:0] g;
        logic [1:0] flip;
        logic [2:0] k;
        logic       bad;
        int         expErr = 0;
        logic [7:0] expCov = 8'h00;
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        // Five vectors with carry stuck low: only stimulus 3 is wrong.
        for (int i = 0; i < 5; i++) begin
            k = 3'(i);
            g = goodOut(k);
            step(1'b0, 1'b1, k, g[1], 1'b0, p);
        end
        nVec++; if (err_cnt !== 8'd1 || busy !== 1'b1) begin nMis++; $display("[TB] FAIL pre_restart: err_cnt=%0d busy=%b want 1/1", err_cnt, busy); end
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        nVec++; if (err_cnt !== 8'd0 || cov !== 8'h00 || busy !== 1'b1 || done !== 1'b0) begin nMis++; $display("[TB] FAIL restart_clear: err_cnt=%0d cov=%h busy=%b done=%b", err_cnt, cov, busy, done); end
        for (int i = 0; i < 16; i++) begin
            k    = 3'($urandom_range(0, 7));
            g    = goodOut(k);
            bad  = ($urandom_range(0, 3) == 0);
            flip = bad ? 2'($urandom_range(1, 3)) : 2'b00;
            if (bad) expErr++;
            expCov = expCov | (8'd1 << k);
            step(1'b0, 1'b1, k, g[1] ^ flip[1], g[0] ^ flip[0], p);
            nVec++; if (p !== bad) begin nMis++; $display("[TB] FAIL random_pulse[%0d]: got %b want %b", i, p, bad); end
            if (i == 14) begin
                nVec++; if (done !== 1'b0 || busy !== 1'b1) begin nMis++; $display("[TB] FAIL restart_early_done: done=%b busy=%b want 0/1", done, busy); end
            end
        end
        nVec++; if (done !== 1'b1) begin nMis++; $display("[TB] FAIL random_done: got %b want 1", done); end
        nVec++; if (err_cnt !== 8'(expErr)) begin nMis++; $display("[TB] FAIL random_err_cnt: got %0d want %0d", err_cnt, expErr); end
        nVec++; if (cov !== expCov) begin nMis++; $display("[TB] FAIL random_cov: got %h want %h", cov, expCov); end
        nVec++; if (pass !== ((expErr == 0) && (expCov == 8'hFF))) begin nMis++; $display("[TB] FAIL random_pass: got %b want %b", pass, ((expErr == 0) && (expCov == 8'hFF))); end
    endtask

    task automatic test_start_vld_rst();
        logic       p;
        logic [1:0] g;
        logic [2:0] k;
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        for (int i = 0; i < 2; i++) begin
            g = goodOut(3'(i));
            step(1'b0, 1'b1, 3'(i), g[1], g[0], p);
        end
        // start together with a bad vector: the vector must be dropped.
        step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, p);
        nVec++; if (p !== 1'b0 || err_cnt !== 8'd0 || cov !== 8'h00 || busy !== 1'b1) begin nMis++; $display("[TB] FAIL start_vld_drop: pulse=%b err_cnt=%0d cov=%h busy=%b", p, err_cnt, cov, busy); end
        for (int i = 0; i < 15; i++) begin
            k = 3'(i % 8);
            g = goodOut(k);
            step(1'b0, 1'b1, k, g[1], g[0], p);
        end
        nVec++; if (done !== 1'b0) begin nMis++; $display("[TB] FAIL drop_vec_cnt: done=%b after 15 vectors want 0", done); end
        g = goodOut(3'd7);
        step(1'b0, 1'b1, 3'd7, g[1], g[0], p);
        nVec++; if (done !== 1'b1 || pass !== 1'b1) begin nMis++; $display("[TB] FAIL drop_run_end: done=%b pass=%b want 1/1", done, pass); end
        // Mid-run reset after four carry errors.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        for (int i = 0; i < 4; i++) begin
            k = (i == 0) ? 3'd3 : (i == 1) ? 3'd5 : (i == 2) ? 3'd6 : 3'd7;
            g = goodOut(k);
            step(1'b0, 1'b1, k, g[1], 1'b0, p);
        end
        nVec++; if (err_cnt !== 8'd4 || p !== 1'b1) begin nMis++; $display("[TB] FAIL pre_rst: err_cnt=%0d pulse=%b want 4/1", err_cnt, p); end
        rst = 1'b1;
        step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, p);
        nVec++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || p !== 1'b0 || err_cnt !== 8'd0 || cov !== 8'h00) begin nMis++; $display("[TB] FAIL mid_rst: busy=%b done=%b pass=%b pulse=%b err_cnt=%0d cov=%h want all 0", busy, done, pass, p, err_cnt, cov); end
        rst = 1'b0;
        // IDLE must ignore vectors.
        step(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, p);
        nVec++; if (p !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'd0 || cov !== 8'h00) begin nMis++; $display("[TB] FAIL idle_ignore: pulse=%b busy=%b err_cnt=%0d cov=%h", p, busy, err_cnt, cov); end
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, p);
    endtask

`ifdef FULL_ADDER_CHK_FIRST_ERR_EN
    task automatic test_first_err();
        logic       p;
        logic [1:0] g;
        logic [2:0] k;
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        nVec++; if (first_err !== 6'd0) begin nMis++; $display("[TB] FAIL first_err_clear: got %b want 000000", first_err); end
        for (int i = 0; i < 2; i++) begin
            g = goodOut(3'(i));
            step(1'b0, 1'b1, 3'(i), g[1], g[0], p);
        end
        step(1'b0, 1'b1, 3'b110, 1'b1, 1'b1, p);
        step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, p);
        nVec++; if (first_err !== 6'b110111) begin nMis++; $display("[TB] FAIL first_err_capture: got %b want 110111", first_err); end
        for (int i = 0; i < 12; i++) begin
            k = 3'(i % 8);
            step(1'b0, 1'b1, k, 1'b1, 1'b1, p);
        end
        nVec++; if (first_err !== 6'b110111 || done !== 1'b1) begin nMis++; $display("[TB] FAIL first_err_hold: got %b done=%b want 110111/1", first_err, done); end
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, p);
        nVec++; if (first_err !== 6'd0) begin nMis++; $display("[TB] FAIL first_err_restart: got %b want 000000", first_err); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in_vld = 1'b0;
        ai = 1'b0; bi = 1'b0; ci = 1'b0; so = 1'b0; co = 1'b0;
        @(negedge clk);
        test_reset();
        test_all_correct();
        test_stuck_co();
        test_partial_cov();
        test_restart_random();
        test_start_vld_rst();
`ifdef FULL_ADDER_CHK_FIRST_ERR_EN
        test_first_err();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
